// File: rtl/majority_event_display_pkg.sv
// majority_event_display_pkg: debounce FSM states and seven-segment encoding shared by the display slice.
package majority_event_display_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  // Segment order {g,f,e,d,c,b,a}, active-high; non-BCD codes blank the digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/majority_event_display_input_debouncer.sv
// majority_event_display_input_debouncer: 2-flop synchronizer plus four-state debounce FSM.
module majority_event_display_input_debouncer
  import majority_event_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_detect,
  output logic o_level,
  output logic o_rise
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_dcnt;
  logic [DW-1:0] w_dcnt_nxt;
  logic          w_done;
  assign w_done  = r_dcnt == DW'(DEBOUNCE_CYCLES - 1);
  assign o_level = (r_state == IDLE_HIGH) || (r_state == WAIT_LOW);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE_LOW;
      r_dcnt  <= '0;
    end else begin
      r_s1    <= i_detect;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end
  // o_rise is the acceptance strobe, so the top registers count and event on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    o_rise      = 1'b0;
    case (r_state)
      IDLE_LOW: if (r_s2) begin
        w_state_nxt = WAIT_HIGH;
        w_dcnt_nxt  = '0;
      end
      WAIT_HIGH: if (!r_s2) w_state_nxt = IDLE_LOW;
        else if (w_done) begin
          w_state_nxt = IDLE_HIGH;
          o_rise      = 1'b1;
        end else w_dcnt_nxt = r_dcnt + 1'b1;
      IDLE_HIGH: if (!r_s2) begin
        w_state_nxt = WAIT_LOW;
        w_dcnt_nxt  = '0;
      end
      WAIT_LOW: if (r_s2) w_state_nxt = IDLE_HIGH;
        else if (w_done) w_state_nxt = IDLE_LOW;
        else w_dcnt_nxt = r_dcnt + 1'b1;
    endcase
  end
endmodule

// File: rtl/majority_event_display.sv
// majority_event_display: debounced majority events counted mod 10 onto a seven-segment digit with heartbeat dp.
module majority_event_display
  import majority_event_display_pkg::*;
#(
  parameter int MAX_COUNT       = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_in,
  input  logic       clr,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       level_out,
  output logic [3:0] count_out,
  output logic       event_pulse,
  output logic       wrap_pulse
);
  localparam int HW = $clog2(MAX_COUNT);
  logic          w_rise;
  logic          w_hb;
  logic          w_at_nine;
  logic [HW-1:0] r_hcnt;
  logic [3:0]    r_count;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_event;
  logic          r_wrap;
  majority_event_display_input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .rst     (rst),
    .i_detect(detect_in),
    .o_level (level_out),
    .o_rise  (w_rise)
  );
  assign w_hb      = r_hcnt == HW'(MAX_COUNT - 1);
  assign w_at_nine = r_count == 4'd9;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 4'd0;
      r_seg   <= SEG_0;
      r_dp    <= 1'b0;
      r_event <= 1'b0;
      r_wrap  <= 1'b0;
      r_hcnt  <= '0;
    end else begin
      r_event <= w_rise;
      r_wrap  <= w_rise && !clr && w_at_nine;
      r_count <= clr ? 4'd0 : w_rise ? (w_at_nine ? 4'd0 : r_count + 4'd1) : r_count;
      r_seg   <= bcd_to_seg(r_count);
      r_hcnt  <= w_hb ? '0 : r_hcnt + 1'b1;
      r_dp    <= r_dp ^ w_hb;
    end
  end
  assign seg_out     = r_seg;
  assign dp_out      = r_dp;
  assign count_out   = r_count;
  assign event_pulse = r_event;
  assign wrap_pulse  = r_wrap;
endmodule

// File: tb/tb_majority_event_display.sv
// tb_majority_event_display: directed scenarios with hand-computed expectations at D=4, MAX_COUNT=8.
module tb_majority_event_display;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       detect_in = 1'b0;
  logic       clr = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       level_out;
  logic [3:0] count_out;
  logic       event_pulse;
  logic       wrap_pulse;
  int         vectors = 0;
  int         miscompares = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  majority_event_display #(.MAX_COUNT(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .detect_in  (detect_in),
    .clr        (clr),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .level_out  (level_out),
    .count_out  (count_out),
    .event_pulse(event_pulse),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (seg_out !== 7'h3F) begin miscompares++; $display("FAIL reset_seg got %h want 3f", seg_out); end
    vectors++;
    if (count_out !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count_out); end
    vectors++;
    if (dp_out !== 1'b0 || level_out !== 1'b0) begin miscompares++; $display("FAIL reset_dp_level got dp=%b lvl=%b want 0 0", dp_out, level_out); end
    vectors++;
    if (event_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got ev=%b wr=%b want 0 0", event_pulse, wrap_pulse); end
    rst = 1'b0;
  endtask

  task automatic test_rise;
    detect_in = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      vectors++;
      if (event_pulse !== 1'b0 || count_out !== 4'd0 || level_out !== 1'b0) begin
        miscompares++;
        $display("FAIL rise_early edge %0d got ev=%b cnt=%0d lvl=%b want 0 0 0", e, event_pulse, count_out, level_out);
      end
    end
    tick();
    vectors++;
    if (event_pulse !== 1'b1) begin miscompares++; $display("FAIL rise_event got %b want 1", event_pulse); end
    vectors++;
    if (count_out !== 4'd1) begin miscompares++; $display("FAIL rise_count got %0d want 1", count_out); end
    vectors++;
    if (level_out !== 1'b1 || wrap_pulse !== 1'b0) begin miscompares++; $display("FAIL rise_level got lvl=%b wr=%b want 1 0", level_out, wrap_pulse); end
    vectors++;
    if (seg_out !== 7'h3F) begin miscompares++; $display("FAIL rise_seg_lag got %h want 3f", seg_out); end
    tick();
    vectors++;
    if (seg_out !== 7'h06) begin miscompares++; $display("FAIL rise_seg got %h want 06", seg_out); end
    vectors++;
    if (event_pulse !== 1'b0) begin miscompares++; $display("FAIL rise_event_width got %b want 0", event_pulse); end
  endtask

  task automatic test_glitch;
    bit seen = 1'b0;
    detect_in = 1'b0;
    repeat (12) begin
      tick();
      if (event_pulse === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL fall_event got 1 want 0"); end
    vectors++;
    if (level_out !== 1'b0 || count_out !== 4'd1) begin miscompares++; $display("FAIL fall_state got lvl=%b cnt=%0d want 0 1", level_out, count_out); end
    detect_in = 1'b1;
    repeat (3) tick();
    detect_in = 1'b0;
    repeat (15) begin
      tick();
      vectors++;
      if (event_pulse !== 1'b0 || level_out !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch got ev=%b lvl=%b want 0 0", event_pulse, level_out);
      end
    end
    vectors++;
    if (count_out !== 4'd1 || seg_out !== 7'h06) begin miscompares++; $display("FAIL glitch_count got cnt=%0d seg=%h want 1 06", count_out, seg_out); end
  endtask

  task automatic test_wrap;
    bit found;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if (count_out !== 4'd0) begin miscompares++; $display("FAIL clr_count got %0d want 0", count_out); end
    for (int i = 1; i <= 10; i++) begin
      detect_in = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        tick();
        if (event_pulse === 1'b1) found = 1'b1;
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL wrap_timeout event %0d got none want pulse", i); end
      vectors++;
      if (count_out !== 4'(i % 10)) begin miscompares++; $display("FAIL wrap_count event %0d got %0d want %0d", i, count_out, i % 10); end
      vectors++;
      if (wrap_pulse !== (i == 10)) begin miscompares++; $display("FAIL wrap_pulse event %0d got %b want %b", i, wrap_pulse, i == 10); end
      tick();
      vectors++;
      if (seg_out !== seg_tab[i % 10] || wrap_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_seg event %0d got seg=%h wr=%b want %h 0", i, seg_out, wrap_pulse, seg_tab[i % 10]);
      end
      detect_in = 1'b0;
      repeat (10) tick();
    end
  endtask

  task automatic test_clr_event;
    bit found;
    for (int i = 1; i <= 5; i++) begin
      detect_in = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        tick();
        if (event_pulse === 1'b1) found = 1'b1;
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL clr_setup_timeout event %0d got none want pulse", i); end
      detect_in = 1'b0;
      repeat (10) tick();
    end
    vectors++;
    if (count_out !== 4'd5) begin miscompares++; $display("FAIL clr_setup_count got %0d want 5", count_out); end
    detect_in = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if (event_pulse !== 1'b1) begin miscompares++; $display("FAIL clr_event got %b want 1", event_pulse); end
    vectors++;
    if (count_out !== 4'd0 || wrap_pulse !== 1'b0) begin miscompares++; $display("FAIL clr_wins got cnt=%0d wr=%b want 0 0", count_out, wrap_pulse); end
    vectors++;
    if (level_out !== 1'b1) begin miscompares++; $display("FAIL clr_level got %b want 1", level_out); end
    tick();
    vectors++;
    if (count_out !== 4'd0 || seg_out !== 7'h3F) begin miscompares++; $display("FAIL clr_after got cnt=%0d seg=%h want 0 3f", count_out, seg_out); end
    detect_in = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_heartbeat;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      vectors++;
      if (dp_out !== ((c / 8) % 2 == 1)) begin
        miscompares++;
        $display("FAIL heartbeat cycle %0d got %b want %b", c, dp_out, (c / 8) % 2 == 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    detect_in = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    detect_in = 1'b0;
    tick();
    vectors++;
    if (seg_out !== 7'h3F || count_out !== 4'd0 || dp_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs got seg=%h cnt=%0d dp=%b want 3f 0 0", seg_out, count_out, dp_out);
    end
    vectors++;
    if (level_out !== 1'b0 || event_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_flags got lvl=%b ev=%b wr=%b want 0 0 0", level_out, event_pulse, wrap_pulse);
    end
    rst = 1'b0;
    repeat (12) begin
      tick();
      if (event_pulse === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen || level_out !== 1'b0 || count_out !== 4'd0) begin
      miscompares++;
      $display("FAIL midrst_after got ev_seen=%b lvl=%b cnt=%0d want 0 0 0", seen, level_out, count_out);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_wrap();
    test_clr_event();
    test_heartbeat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
endmodule
